// File: rtl/sdfm_sinc_filter.sv
// Sinc^N (N=1..3) decimation filter for one sigma-delta channel.
// Integrators run on modulator strobes; the comb chain runs once per decimation tick.
module sdfm_sinc_filter #(
    parameter int ACC_W = 32
) (
    input  logic        SYSCLK,
    input  logic        SYSRST,
    input  logic        enable,
    input  logic [1:0]  order,
    input  logic [7:0]  osr,
    input  logic [4:0]  shift,
    input  logic        mod_data,
    input  logic        mod_strobe,
    output logic [31:0] data_out,
    output logic        data_update
);
    typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [1:0]         settle_q, settle_d;
    logic [1:0]         order_q;
    logic [7:0]         osr_q;
    logic [4:0]         shift_q;
    logic [1:0]         n_stages;
    logic [ACC_W-1:0]   i1_q, i2_q, i3_q;
    logic [ACC_W-1:0]   d1_q, d2_q, d3_q;
    logic [ACC_W-1:0]   tap, c1, c2, c3, c_n, x;
    logic [7:0]         cnt_q;
    logic               tick_q;
    logic               emit;
    logic [31:0]        dout_q;
    logic               upd_q;

    assign n_stages = (order_q == 2'b00) ? 2'd1 : (order_q == 2'b01) ? 2'd2 : 2'd3;
    assign x        = {{(ACC_W-1){1'b0}}, mod_data};

    always_comb begin
        tap = i3_q;
        c_n = c3;
        case (n_stages)
            2'd1:    begin tap = i1_q; c_n = c1; end
            2'd2:    begin tap = i2_q; c_n = c2; end
            default: begin tap = i3_q; c_n = c3; end
        endcase
    end

    assign c1 = tap - d1_q;
    assign c2 = c1 - d2_q;
    assign c3 = c2 - d3_q;

    // The settle counter lives alongside the state so SETTLE->RUN happens on the Nth tick.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        emit     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d  = SETTLE;
                settle_d = 2'd0;
            end
            SETTLE: if (tick_q) begin
                settle_d = settle_q + 2'd1;
                if (settle_q == n_stages - 2'd1) state_d = RUN;
            end
            RUN:     emit = tick_q;
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d  = IDLE;
            settle_d = 2'd0;
            emit     = 1'b0;
        end
    end

    always_ff @(posedge SYSCLK or posedge SYSRST) begin
        if (SYSRST) begin
            state_q  <= IDLE;
            settle_q <= 2'd0;
            order_q  <= 2'b00;
            osr_q    <= 8'd2;
            shift_q  <= 5'd0;
            i1_q     <= '0;
            i2_q     <= '0;
            i3_q     <= '0;
            d1_q     <= '0;
            d2_q     <= '0;
            d3_q     <= '0;
            cnt_q    <= 8'd0;
            tick_q   <= 1'b0;
            dout_q   <= 32'd0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            upd_q    <= emit;
            if (emit) dout_q <= 32'(c_n >> shift_q);
            if (!enable) begin
                order_q <= order;
                osr_q   <= (osr < 8'd2) ? 8'd2 : osr;
                shift_q <= shift;
                i1_q    <= '0;
                i2_q    <= '0;
                i3_q    <= '0;
                d1_q    <= '0;
                d2_q    <= '0;
                d3_q    <= '0;
                cnt_q   <= 8'd0;
                tick_q  <= 1'b0;
            end else begin
                tick_q <= mod_strobe && (cnt_q == osr_q);
                if (mod_strobe) begin
                    cnt_q <= (cnt_q == osr_q) ? 8'd0 : cnt_q + 8'd1;
                    i1_q  <= i1_q + x;
                    i2_q  <= (n_stages >= 2'd2) ? i2_q + i1_q : '0;
                    i3_q  <= (n_stages == 2'd3) ? i3_q + i2_q : '0;
                end
                // Comb uses the tap as registered at the tick, before any same-cycle strobe lands.
                if (tick_q) begin
                    d1_q <= tap;
                    d2_q <= (n_stages >= 2'd2) ? c1 : '0;
                    d3_q <= (n_stages == 2'd3) ? c2 : '0;
                end
            end
        end
    end

    assign data_out    = dout_q;
    assign data_update = upd_q & enable;
endmodule
